// File: rtl/pc_unit.sv
// Program-counter unit: selects the next fetch address from trap, trap return,
// redirect, return-address-stack prediction or sequential increment.
module pc_unit #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              INSTR_BYTES = 4,
    parameter int              RAS_DEPTH   = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           stall,
    input  logic                           redirect_valid,
    input  logic [XLEN-1:0]                redirect_target,
    input  logic                           trap,
    input  logic [XLEN-1:0]                trap_vector,
    input  logic                           mret,
    input  logic                           ras_push,
    input  logic                           ras_pop,
    output logic [XLEN-1:0]                current_pc,
    output logic [XLEN-1:0]                epc,
    output logic [XLEN-1:0]                ras_top,
    output logic [$clog2(RAS_DEPTH):0]     ras_count
);

    localparam int              PTR_W      = $clog2(RAS_DEPTH);
    localparam int              CNT_W      = PTR_W + 1;
    localparam logic [XLEN-1:0] INC        = XLEN'(INSTR_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INSTR_BYTES - 1));
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(RAS_DEPTH);

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  epc_q, epc_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [XLEN-1:0]  mem_q [RAS_DEPTH];
    logic [XLEN-1:0]  mem_d [RAS_DEPTH];

    logic             ras_en;
    logic             ras_nonempty;
    logic             do_push;
    logic             do_pop;
    logic [XLEN-1:0]  seq_pc;
    logic [XLEN-1:0]  push_val;
    logic [PTR_W-1:0] ptr_inc;
    logic [XLEN-1:0]  top_val;

    function automatic logic [XLEN-1:0] align(input logic [XLEN-1:0] addr);
        return addr & ALIGN_MASK;
    endfunction

    assign ras_nonempty = (count_q != '0);
    assign top_val      = ras_nonempty ? mem_q[ptr_q] : '0;

    always_comb begin
        ras_en   = !stall && !trap && !mret;
        do_pop   = ras_en && ras_pop && ras_nonempty;
        do_push  = ras_en && ras_push;
        seq_pc   = pc_q + INC;
        push_val = align(seq_pc);
        ptr_inc  = ptr_q + 1'b1;

        pc_d    = seq_pc;
        epc_d   = epc_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        mem_d   = mem_q;

        if (trap) begin
            pc_d  = align(trap_vector);
            epc_d = align(pc_q);
        end else if (mret) begin
            pc_d = epc_q;
        end else if (redirect_valid) begin
            pc_d = align(redirect_target);
        end else if (stall) begin
            pc_d = pc_q;
        end else if (do_pop) begin
            pc_d = top_val;
        end

        // A push and pop together swap the top entry in place; an empty stack
        // has nothing to pop, so that case degrades to a plain push.
        if (do_push && do_pop) begin
            mem_d[ptr_q] = push_val;
        end else if (do_push) begin
            ptr_d          = ptr_inc;
            mem_d[ptr_inc] = push_val;
            if (count_q != CNT_FULL) begin
                count_d = count_q + 1'b1;
            end
        end else if (do_pop) begin
            ptr_d   = ptr_q - 1'b1;
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            epc_q   <= '0;
            ptr_q   <= '0;
            count_q <= '0;
            mem_q   <= '{default: '0};
        end else begin
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

    assign current_pc = pc_q;
    assign epc        = epc_q;
    assign ras_top    = top_val;
    assign ras_count  = count_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit: sequential wrap, stall/redirect,
// trap/mret, RAS call/return, overflow, push+pop and asynchronous reset.
module tb_pc_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap;
    logic [31:0] trap_vector;
    logic        mret;
    logic        ras_push;
    logic        ras_pop;
    logic [31:0] current_pc;
    logic [31:0] epc;
    logic [31:0] ras_top;
    logic [2:0]  ras_count;

    int num_checks = 0;
    int num_errors = 0;

    pc_unit #(
        .XLEN       (32),
        .RESET_PC   (32'hFFFF_FFF8),
        .INSTR_BYTES(4),
        .RAS_DEPTH  (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .trap           (trap),
        .trap_vector    (trap_vector),
        .mret           (mret),
        .ras_push       (ras_push),
        .ras_pop        (ras_pop),
        .current_pc     (current_pc),
        .epc            (epc),
        .ras_top        (ras_top),
        .ras_count      (ras_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of controls, let the edge take them, then idle the inputs.
    task automatic applyStimulus(input logic st, input logic rv, input logic [31:0] rt,
                                 input logic tr, input logic [31:0] tv, input logic mr,
                                 input logic push, input logic pop);
        stall           = st;
        redirect_valid  = rv;
        redirect_target = rt;
        trap            = tr;
        trap_vector     = tv;
        mret            = mr;
        ras_push        = push;
        ras_pop         = pop;
        @(posedge clk);
        #1;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        trap            = 1'b0;
        trap_vector     = '0;
        mret            = 1'b0;
        ras_push        = 1'b0;
        ras_pop         = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        num_checks++;
        assert (observed === expected)
        else begin
            num_errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        reset           = 1'b1;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        trap            = 1'b0;
        trap_vector     = '0;
        mret            = 1'b0;
        ras_push        = 1'b0;
        ras_pop         = 1'b0;

        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("reset_pc",    current_pc,      32'hFFFF_FFF8);
        checkOutput("reset_epc",   epc,             32'h0);
        checkOutput("reset_count", 32'(ras_count),  32'h0);
        checkOutput("reset_top",   ras_top,         32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Sequential increment and wrap past the top of the address space
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 0, 0);
        checkOutput("seq_first", current_pc, 32'hFFFF_FFFC);
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 0, 0);
        checkOutput("seq_wrap", current_pc, 32'h0000_0000);

        // Stall holds; redirect overrides stall and is aligned
        applyStimulus(0, 1, 32'h100, 0, 32'h0, 0, 0, 0);
        checkOutput("redir_0x100", current_pc, 32'h100);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 32'h0, 0, 32'h0, 0, 0, 0);
            checkOutput("stall_hold", current_pc, 32'h100);
        end
        applyStimulus(1, 1, 32'h203, 0, 32'h0, 0, 0, 0);
        checkOutput("stall_redir", current_pc, 32'h200);

        // Trap, return from trap, and trap winning over mret
        applyStimulus(0, 1, 32'h40, 0, 32'h0, 0, 0, 0);
        checkOutput("redir_0x40", current_pc, 32'h40);
        applyStimulus(0, 0, 32'h0, 1, 32'h800, 0, 0, 0);
        checkOutput("trap_pc",  current_pc, 32'h800);
        checkOutput("trap_epc", epc,        32'h40);
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 0, 0);
        checkOutput("handler_seq", current_pc, 32'h804);
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 1, 0, 0);
        checkOutput("mret_pc",  current_pc, 32'h40);
        checkOutput("mret_epc", epc,        32'h40);
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 0, 0);
        checkOutput("after_mret", current_pc, 32'h44);
        applyStimulus(0, 0, 32'h0, 1, 32'h803, 1, 0, 0);
        checkOutput("trap_mret_pc",  current_pc, 32'h800);
        checkOutput("trap_mret_epc", epc,        32'h44);

        // RAS call with redirect, return, and pop on empty
        applyStimulus(0, 1, 32'h10, 0, 32'h0, 0, 0, 0);
        checkOutput("redir_0x10", current_pc, 32'h10);
        applyStimulus(0, 1, 32'h500, 0, 32'h0, 0, 1, 0);
        checkOutput("call_pc",    current_pc,     32'h500);
        checkOutput("call_top",   ras_top,        32'h14);
        checkOutput("call_count", 32'(ras_count), 32'h1);
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 0, 1);
        checkOutput("ret_pc",    current_pc,     32'h14);
        checkOutput("ret_count", 32'(ras_count), 32'h0);
        checkOutput("ret_top",   ras_top,        32'h0);
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 0, 1);
        checkOutput("empty_pop_pc",    current_pc,     32'h18);
        checkOutput("empty_pop_count", 32'(ras_count), 32'h0);

        // Overflow: five pushes into a four-deep stack
        applyStimulus(0, 1, 32'h0, 0, 32'h0, 0, 0, 0);
        checkOutput("redir_0x0", current_pc, 32'h0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 1, 0);
        end
        checkOutput("ovf_pc",    current_pc,     32'h14);
        checkOutput("ovf_count", 32'(ras_count), 32'h4);
        checkOutput("ovf_top",   ras_top,        32'h14);
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 0, 1);
        checkOutput("ovf_pop1", current_pc, 32'h14);
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 0, 1);
        checkOutput("ovf_pop2", current_pc, 32'h10);
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 0, 1);
        checkOutput("ovf_pop3", current_pc, 32'hC);
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 0, 1);
        checkOutput("ovf_pop4",       current_pc,     32'h8);
        checkOutput("ovf_pop4_count", 32'(ras_count), 32'h0);
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 0, 1);
        checkOutput("ovf_pop5",       current_pc,     32'hC);
        checkOutput("ovf_pop5_count", 32'(ras_count), 32'h0);

        // Simultaneous push and pop replaces the top in place
        applyStimulus(0, 1, 32'h20, 0, 32'h0, 0, 0, 0);
        applyStimulus(0, 1, 32'h60, 0, 32'h0, 0, 1, 0);
        checkOutput("pp_setup_pc",  current_pc, 32'h60);
        checkOutput("pp_setup_top", ras_top,    32'h24);
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 1, 1);
        checkOutput("pp_pc",    current_pc,     32'h24);
        checkOutput("pp_top",   ras_top,        32'h64);
        checkOutput("pp_count", 32'(ras_count), 32'h1);

        // Stalled push is ignored; pop with redirect still pops
        applyStimulus(1, 0, 32'h0, 0, 32'h0, 0, 1, 0);
        checkOutput("stall_push_pc",    current_pc,     32'h24);
        checkOutput("stall_push_count", 32'(ras_count), 32'h1);
        applyStimulus(0, 1, 32'h300, 0, 32'h0, 0, 0, 1);
        checkOutput("pop_redir_pc",    current_pc,     32'h300);
        checkOutput("pop_redir_count", 32'(ras_count), 32'h0);

        // Push something, then assert reset between edges
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 1, 0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_pc",    current_pc,     32'hFFFF_FFF8);
        checkOutput("async_count", 32'(ras_count), 32'h0);
        checkOutput("async_top",   ras_top,        32'h0);
        checkOutput("async_epc",   epc,            32'h0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 0, 0);
        checkOutput("post_reset_seq", current_pc, 32'hFFFF_FFFC);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit, the successor to the single-register PC. It holds the fetch address and selects the next PC from five sources: trap vector, trap return, resolved redirect, return-address-stack (RAS) prediction, or the sequential increment. It also supports pipeline stalls and contains a small circular return-address stack. It sits at the front of the fetch stage, and its `current_pc` drives instruction memory.

## Interface
- `XLEN`, 32, address width in bits
- `RESET_PC`, 0, value loaded into `current_pc` on reset
- `INSTR_BYTES`, 4, sequential increment; power of two
- `RAS_DEPTH`, 4, RAS entries; power of two, ≥2

- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `stall`  in  1  hold PC and RAS this cycle
- `redirect_valid`  in  1  resolved branch/jump; take `redirect_target`
- `redirect_target`  in  XLEN  redirect address
- `trap`  in  1  exception; save `epc`, jump to `trap_vector`
- `trap_vector`  in  XLEN  trap handler address
- `mret`  in  1  return from trap to `epc`
- `ras_push`  in  1  call: push `current_pc + INSTR_BYTES`
- `ras_pop`  in  1  predicted return: next PC = RAS top
- `current_pc`  out  XLEN  fetch address (register)
- `epc`  out  XLEN  saved trap PC (register)
- `ras_top`  out  XLEN  current top-of-stack entry; 0 when empty
- `ras_count`  out  $clog2(RAS_DEPTH)+1  valid entries (register)

## Operation
- Alignment:
  - Every loaded address has its low `log2(INSTR_BYTES)` bits forced to 0.
  - This applies to `trap_vector`, `redirect_target`, `epc` and RAS data.
- Next-PC priority, highest first:
  - `trap`: `current_pc` ← `trap_vector`; `epc` ← `current_pc`.
  - `mret`: `current_pc` ← `epc`.
  - `redirect_valid`: `current_pc` ← `redirect_target`.
  - `stall`: `current_pc` holds.
  - `ras_pop` with `ras_count` ≠ 0: `current_pc` ← `ras_top`.
  - Otherwise: `current_pc` ← `current_pc + INSTR_BYTES`, modulo 2^XLEN (wraps, no flag).
- `trap`, `mret` and `redirect_valid` override `stall`.
- `trap` and `mret` asserted together: trap wins; `epc` is written and `mret` is ignored.
- `epc` changes only on `trap` or reset.
- RAS is a circular buffer with a top pointer and a saturating count.
  - Operations are effective only when `stall`=0, `trap`=0 and `mret`=0.
  - Operations are effective when `redirect_valid`=1, so a JAL/JALR call pushes while redirecting.
- Push:
  - Writes `current_pc + INSTR_BYTES` at top+1 and advances top.
  - `ras_count` increments, saturating at `RAS_DEPTH`.
  - When full, the push overwrites the oldest entry (wrap-around).
- Pop: decrements top and `ras_count`.
- Pop when empty:
  - Ignored; PC falls to the next lower-priority source.
  - `ras_count` stays 0.
- Push and pop in the same cycle:
  - The PC takes the old top (if non-empty, and no higher source is active).
  - The top entry is replaced by the push value.
  - `ras_count` is unchanged.
  - If the RAS was empty, this behaves as a push only.
- Pop with `redirect_valid`: the pop still occurs, but the PC takes `redirect_target`.

## Timing
- Reset values, applied asynchronously while `reset`=1:
  - `current_pc`=`RESET_PC`, `epc`=0, `ras_count`=0, `ras_top`=0.
  - All RAS entries and the pointer are 0.
- First edge after `reset` falls, with no other inputs: `current_pc`=`RESET_PC + INSTR_BYTES`.
- Latency: one cycle from control inputs to `current_pc`, `epc` and `ras_count`.
- `ras_top` is combinational from RAS state and reflects the stack after the last edge.
- Reset asserted mid-operation clears everything regardless of other inputs.
- Inputs sampled in the reset-deassertion cycle take effect normally at the next edge.

## Test plan
- Sequential and wrap: with `RESET_PC`=0xFFFF_FFF8, release reset -> `current_pc` goes 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 on successive edges.
- Stall versus redirect: with PC=0x100, apply `stall`=1 for 3 cycles -> PC stays 0x100. Then `stall`=1 with `redirect_valid`=1, target 0x203 -> PC=0x200.
- Trap and mret: at PC=0x40, `trap`=1, vector 0x800 -> PC=0x800, `epc`=0x40. Later `mret`=1 -> PC=0x40. With `trap`+`mret` together at PC=0x44 -> PC=0x800, `epc`=0x44.
- RAS call/return:
  - At PC=0x10, push with redirect to 0x500 -> PC=0x500, `ras_top`=0x14, `ras_count`=1.
  - Then pop -> PC=0x14, `ras_count`=0.
  - Pop again -> PC=0x18, count stays 0.
- RAS overflow with `RAS_DEPTH`=4: 5 pushes from PCs 0x0, 0x4, 0x8, 0xC, 0x10 -> `ras_count`=4. Four pops return 0x14, 0x10, 0xC, 0x8; a fifth pop is ignored.
- Simultaneous push and pop, plus async reset: with `ras_top`=0x24 at PC=0x60, push+pop -> PC=0x24, `ras_top`=0x64, count unchanged. Asserting `reset` between clock edges -> `current_pc`=`RESET_PC` and `ras_count`=0 immediately.
